// File: rtl/fpga_rst_seq_pkg.sv
// Shared types and constants for the multi-domain reset sequencer.
// Cause bit positions and the sequencer state encoding live here.
package fpga_rst_seq_pkg;

    localparam int CAUSE_W      = 5;
    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_BTN    = 1;
    localparam int CAUSE_SYSREQ = 2;
    localparam int CAUSE_LOCKUP = 3;
    localparam int CAUSE_WDOG   = 4;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fpga_rst_sequencer_debounce.sv
// Two-flop synchroniser and symmetric debounce filter for the board reset button.
// press_lvl is 1 while the (active-low) button is considered pressed.
module fpga_rst_debounce #(
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
    input  logic SYSCLK,
    input  logic nRST,
    input  logic ck_rst,
    output logic press_lvl
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples whose level disagrees with the current state.
    always_comb begin
        press_d = press_q;
        cnt_d   = '0;
        if (sync2_q == press_q) begin
            if (cnt_q >= CNT_LAST) begin
                press_d = ~press_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!nRST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ck_rst;
            sync2_q <= sync1_q;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_lvl = press_q;

endmodule

// File: rtl/fpga_rst_sequencer.sv
// Multi-domain reset sequencer: holds all domains in reset, releases them in
// order with a fixed gap, and records which source caused the last reset.
module fpga_rst_sequencer
    import fpga_rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int DEBOUNCE    = 8,
    parameter int LOCKUP_EN   = 1
) (
    input  logic               SYSCLK,
    input  logic               nRST,
    input  logic               ck_rst,
    input  logic               SYSRESETREQ,
    input  logic               LOCKUP,
    input  logic               WDOG_RST,
    input  logic               CAUSE_CLR,
    output logic [NUM_CH-1:0]  nRST_OUT,
    output logic               RST_DONE,
    output logic [CAUSE_W-1:0] RST_CAUSE
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STAGE_GAP, DEBOUNCE) + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CH_W-1:0]  CH_PENULT = CH_W'(NUM_CH - 2);

    logic               press_lvl;
    logic               lockup_req;
    logic               req;
    logic [CAUSE_W-1:0] src;
    logic [CAUSE_W-1:0] src_prev_q;
    logic [CAUSE_W-1:0] src_prev_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;

    rst_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]    ch_q;
    logic [NUM_CH-1:0]  rst_out_q;
    logic               done_q;

    fpga_rst_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_debounce (
        .SYSCLK    (SYSCLK),
        .nRST      (nRST),
        .ck_rst    (ck_rst),
        .press_lvl (press_lvl)
    );

    assign lockup_req = (LOCKUP_EN != 0) && LOCKUP;

    always_comb begin
        src                = '0;
        src[CAUSE_BTN]     = press_lvl;
        src[CAUSE_SYSREQ]  = SYSRESETREQ;
        src[CAUSE_LOCKUP]  = lockup_req;
        src[CAUSE_WDOG]    = WDOG_RST;
        req                = |src;
        src_prev_d         = src;
        // A set on a rising request beats a simultaneous clear.
        cause_d            = (CAUSE_CLR ? '0 : cause_q) | (src & ~src_prev_q);
    end

    always_ff @(posedge SYSCLK) begin
        if (!nRST) begin
            src_prev_q <= '0;
            cause_q    <= CAUSE_W'(1) << CAUSE_POR;
        end else begin
            src_prev_q <= src_prev_d;
            cause_q    <= cause_d;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!nRST || req) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q >= HOLD_LAST) begin
                        cnt_q     <= '0;
                        ch_q      <= '0;
                        rst_out_q <= NUM_CH'(1);
                        if (NUM_CH == 1) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q >= GAP_LAST) begin
                        cnt_q     <= '0;
                        ch_q      <= ch_q + 1'b1;
                        rst_out_q <= (rst_out_q << 1) | NUM_CH'(1);
                        if (ch_q >= CH_PENULT) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_out_q <= '1;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q   <= ST_ASSERT;
                    cnt_q     <= '0;
                    rst_out_q <= '0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign nRST_OUT  = rst_out_q;
    assign RST_DONE  = done_q;
    assign RST_CAUSE = cause_q;

endmodule
